// File: rtl/bar_word_unpacker.sv
// -----------------------------------------------------------------------------
// bar_word_unpacker
//
// Receive side of the numbers_e/bar_t word format. Each raw 32-bit foo_t word
// accepted on the input stream is reinterpreted as bar_t:
//     b_member  = word[31:29]   (numbers_e, legal values 0..4)
//     b_padding = word[28:0]
// The decoded fields are queued in a small FIFO and re-emitted on the output
// stream. Members 5..7 are flagged as illegal and counted.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   in_valid     in_word is valid
//   in_ready     block can accept in_word (= FIFO not full, registered state only)
//   in_word      raw foo_t word
//   out_valid    FIFO head valid
//   out_ready    consumer takes the head this cycle
//   out_member   head b_member (raw, never remapped), 0 when empty
//   out_padding  head b_padding, 0 when empty
//   out_illegal  head member > 4, 0 when empty
//   clr_cnt      synchronous clear of both counters (wins over increment)
//   word_cnt     words accepted, saturating
//   illegal_cnt  illegal words accepted, saturating
// -----------------------------------------------------------------------------
module bar_word_unpacker #(
    parameter int DEPTH = 2,   // power of two, >= 2
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_member,
    output logic [28:0]      out_padding,
    output logic             out_illegal,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic        illegal;
        logic [2:0]  member;
        logic [28:0] padding;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;

    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_pop;
    logic   w_illegal;
    entry_t w_head;

    assign w_full    = (r_count == OCC_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push    = in_valid & ~w_full;
    assign w_pop     = out_ready & ~w_empty;
    assign w_illegal = (in_word[31:29] >= 3'd5);

    // Empty FIFO presents all-zero fields, so stale or unreset storage is never visible.
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign in_ready    = ~w_full;
    assign out_valid   = ~w_empty;
    assign out_member  = w_head.member;
    assign out_padding = w_head.padding;
    assign out_illegal = w_head.illegal;
    assign word_cnt    = r_word_cnt;
    assign illegal_cnt = r_illegal_cnt;

    // NOTE: the storage array has no reset; validity comes solely from r_count,
    // which keeps the array as plain RAM rather than a bank of resettable flops.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{illegal: w_illegal,
                                 member:  in_word[31:29],
                                 padding: in_word[28:0]};
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_ONE;
                2'b01:   r_count <= r_count - OCC_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Statistics counters saturate at all-ones; clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt    <= '0;
            r_illegal_cnt <= '0;
        end else if (clr_cnt) begin
            r_word_cnt    <= '0;
            r_illegal_cnt <= '0;
        end else if (w_push) begin
            if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + CNT_ONE;
            if (w_illegal && (r_illegal_cnt != '1)) r_illegal_cnt <= r_illegal_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_bar_word_unpacker.sv
// -----------------------------------------------------------------------------
// tb_bar_word_unpacker
//
// Self-checking bench for bar_word_unpacker. Two instances share all inputs:
// dut uses CNT_W=16, dut_s uses CNT_W=4 so counter saturation is reachable.
// A queue-based reference model tracks the expected FIFO contents and the
// expected counter values.
// -----------------------------------------------------------------------------
module tb_bar_word_unpacker;

    localparam int DEPTH   = 2;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 4;
    localparam int MAX_L   = (1 << CNT_W) - 1;
    localparam int MAX_S   = (1 << CNT_W_S) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_word;
    logic        out_ready;
    logic        clr_cnt;

    logic               in_ready,  out_valid,  out_illegal;
    logic [2:0]         out_member;
    logic [28:0]        out_padding;
    logic [CNT_W-1:0]   word_cnt,  illegal_cnt;

    logic               s_in_ready, s_out_valid, s_out_illegal;
    logic [2:0]         s_out_member;
    logic [28:0]        s_out_padding;
    logic [CNT_W_S-1:0] s_word_cnt, s_illegal_cnt;

    bar_word_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_member(out_member), .out_padding(out_padding), .out_illegal(out_illegal),
        .clr_cnt(clr_cnt), .word_cnt(word_cnt), .illegal_cnt(illegal_cnt)
    );

    bar_word_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W_S)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_word(in_word),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_member(s_out_member), .out_padding(s_out_padding), .out_illegal(s_out_illegal),
        .clr_cnt(clr_cnt), .word_cnt(s_word_cnt), .illegal_cnt(s_illegal_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    int m_words, m_ill, m_words_s, m_ill_s;
    int pops;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic int sat_inc(int v, int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [31:0] h;
        logic        hv;
        hv = (mq.size() != 0);
        h  = hv ? mq[0] : 32'h0;
        check("out_valid",   64'(out_valid),   64'(hv));
        check("in_ready",    64'(in_ready),    64'(mq.size() < DEPTH));
        check("out_member",  64'(out_member),  64'(h[31:29]));
        check("out_padding", 64'(out_padding), 64'(h[28:0]));
        check("out_illegal", 64'(out_illegal), 64'(hv && (h[31:29] > 3'd4)));
        check("word_cnt",    64'(word_cnt),    64'(m_words));
        check("illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
        check("s_out_valid", 64'(s_out_valid), 64'(hv));
        check("s_in_ready",  64'(s_in_ready),  64'(mq.size() < DEPTH));
        check("s_head",      64'({s_out_illegal, s_out_member, s_out_padding}),
                             64'({out_illegal, out_member, out_padding}));
        check("s_word_cnt",  64'(s_word_cnt),  64'(m_words_s));
        check("s_ill_cnt",   64'(s_illegal_cnt), 64'(m_ill_s));
    endtask

    task automatic model_reset();
        mq.delete();
        m_words = 0; m_ill = 0; m_words_s = 0; m_ill_s = 0;
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge,
    // and compare everything at the following negedge.
    task automatic step(input logic v, input logic [31:0] w, input logic r, input logic clr);
        logic push, pop, ill;
        in_valid = v; in_word = w; out_ready = r; clr_cnt = clr;
        push = v && (mq.size() < DEPTH);
        pop  = r && (mq.size() > 0);
        ill  = (w[31:29] >= 3'd5);
        @(posedge clk);
        if (pop) begin
            void'(mq.pop_front());
            pops++;
        end
        if (push) mq.push_back(w);
        if (clr) begin
            m_words = 0; m_ill = 0; m_words_s = 0; m_ill_s = 0;
        end else if (push) begin
            m_words   = sat_inc(m_words, MAX_L);
            m_words_s = sat_inc(m_words_s, MAX_S);
            if (ill) begin
                m_ill   = sat_inc(m_ill, MAX_L);
                m_ill_s = sat_inc(m_ill_s, MAX_S);
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; clr_cnt = 1'b0;
        model_reset();
        pops = 0;
        #1;
        compare_all();                              // reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare_all();

        // 1: single word into an empty FIFO
        step(1'b1, 32'h2000_0005, 1'b1, 1'b0);
        check("t1_valid",   64'(out_valid),   64'd1);
        check("t1_member",  64'(out_member),  64'd1);
        check("t1_padding", 64'(out_padding), 64'd5);
        check("t1_illegal", 64'(out_illegal), 64'd0);
        check("t1_words",   64'(word_cnt),    64'd1);
        check("t1_ill",     64'(illegal_cnt), 64'd0);
        drain();

        // 2: every member value, padding = index
        step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            w = {3'(i), 29'(i)};
            step(1'b1, w, 1'b1, 1'b0);
            check("t2_member",  64'(out_member),  64'(i));
            check("t2_illegal", 64'(out_illegal), 64'(i >= 5));
        end
        drain();
        check("t2_words", 64'(word_cnt),    64'd8);
        check("t2_ill",   64'(illegal_cnt), 64'd3);

        // 3: fill with consumer stalled, then pop-only while full, across wrap
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h4000_0100 + 32'(k * 16 + i), 1'b0, 1'b0);
            check("t3_full_ready", 64'(in_ready), 64'd0);
            step(1'b1, 32'h8000_0777, 1'b1, 1'b0);
            check("t3_after_pop_ready", 64'(in_ready), 64'd1);
            check("t3_head_pad", 64'(out_padding), 64'(32'h100 + 32'(k * 16 + 1)));
            drain();
        end

        // 4: 100 cycles of back-to-back streaming
        step(1'b0, 32'h0, 1'b1, 1'b1);
        pops = 0;
        for (int i = 0; i < 100; i++) step(1'b1, $urandom, 1'b1, 1'b0);
        check("t4_words", 64'(word_cnt), 64'd100);
        check("t4_pops",  64'(pops),     64'd99);
        drain();

        // 5: saturation on the narrow-counter instance, then clear with push
        step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 32'hE000_0000, 1'b1, 1'b0);
        check("t5_s_words", 64'(s_word_cnt),    64'd15);
        check("t5_s_ill",   64'(s_illegal_cnt), 64'd15);
        check("t5_ill",     64'(illegal_cnt),   64'd20);
        step(1'b1, 32'hE000_0000, 1'b1, 1'b1);
        check("t5_clr_s_words", 64'(s_word_cnt),  64'd0);
        check("t5_clr_s_ill",   64'(s_illegal_cnt), 64'd0);
        check("t5_clr_words",   64'(word_cnt),    64'd0);
        drain();

        // Randomised traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0));
        drain();

        // 6: asynchronous reset with two words buffered
        step(1'b1, 32'h6000_0011, 1'b0, 1'b0);
        step(1'b1, 32'h6000_0022, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_valid", 64'(out_valid),   64'd0);
        check("t6_words", 64'(word_cnt),    64'd0);
        check("t6_ill",   64'(illegal_cnt), 64'd0);
        compare_all();
        #1 rst_n = 1'b1;
        @(negedge clk);
        compare_all();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("t6_idle_valid", 64'(out_valid), 64'd0);
        step(1'b1, 32'h8000_0033, 1'b0, 1'b0);
        check("t6_first_pad", 64'(out_padding), 64'h33);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
